// File: rtl/fault_event_monitor.sv
// Debounces the classifier fault code, keeps sticky alarm/overflow flags and
// queues each qualified code change as a timestamped event for the host.
module fault_event_monitor #(
    parameter int unsigned DEBOUNCE   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      fault,
    input  logic [31:0]     rms,
    input  logic            alarm_clr,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [1:0]      evt_code,
    output logic [1:0]      evt_prev,
    output logic [31:0]     evt_rms,
    output logic [TS_W-1:0] evt_ts,
    output logic [1:0]      stable,
    output logic            alarm,
    output logic            overflow
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {ST_STABLE, ST_QUALIFY} state_t;

    typedef struct packed {
        logic [1:0]      code;
        logic [1:0]      prev;
        logic [31:0]     rms;
        logic [TS_W-1:0] ts;
    } evt_t;

    state_t          state, state_nx;
    logic [1:0]      cand, cand_nx, stable_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic            qualify;
    logic [TS_W-1:0] ts;

    evt_t            mem [FIFO_DEPTH];
    evt_t            head;
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]  count;
    logic            full, pop, push, drop;

    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        cnt_nx    = cnt;
        stable_nx = stable;
        qualify   = 1'b0;
        if (fault != cand) begin
            cand_nx  = fault;
            cnt_nx   = CNT_W'(1);
            state_nx = (fault == stable) ? ST_STABLE : ST_QUALIFY;
        end else if (state == ST_QUALIFY) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                stable_nx = cand;
                qualify   = 1'b1;
                state_nx  = ST_STABLE;
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign push      = qualify && (!full || pop);
    assign drop      = qualify && full && !pop;

    assign head     = mem[rptr];
    assign evt_code = evt_valid ? head.code : '0;
    assign evt_prev = evt_valid ? head.prev : '0;
    assign evt_rms  = evt_valid ? head.rms  : '0;
    assign evt_ts   = evt_valid ? head.ts   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_STABLE;
            cand     <= '0;
            cnt      <= '0;
            stable   <= '0;
            ts       <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            alarm    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nx;
            cand   <= cand_nx;
            cnt    <= cnt_nx;
            stable <= stable_nx;
            ts     <= ts + TS_W'(1);
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (qualify && cand != 2'b00)          alarm <= 1'b1;
            else if (alarm_clr && stable == 2'b00) alarm <= 1'b0;
            if (drop)           overflow <= 1'b1;
            else if (alarm_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wptr] <= '{code: cand, prev: stable, rms: rms, ts: ts};
    end

endmodule

// File: tb/tb_fault_event_monitor.sv
// Scoreboard bench: a run-length reference model predicts events and flags,
// a negedge monitor compares the DUT's outputs and popped events against it.
module tb_fault_event_monitor;

    localparam int DEB   = 16;
    localparam int DEPTH = 4;
    localparam int TSW   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     fault = 2'b00;
    logic [31:0]    rms = '0;
    logic           alarm_clr = 1'b0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [1:0]     evt_code, evt_prev, stable;
    logic [31:0]    evt_rms;
    logic [TSW-1:0] evt_ts;
    logic           alarm, overflow;

    fault_event_monitor #(.DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH), .TS_W(TSW)) dut (
        .clk(clk), .rst(rst), .fault(fault), .rms(rms),
        .alarm_clr(alarm_clr), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_prev(evt_prev),
        .evt_rms(evt_rms), .evt_ts(evt_ts), .stable(stable),
        .alarm(alarm), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     code;
        logic [1:0]     prev;
        logic [31:0]    rms;
        logic [TSW-1:0] ts;
    } ev_t;

    ev_t            exp_q[$];
    int             occ = 0;
    int             run = 0;
    logic [1:0]     last_m = 2'b00;
    logic [1:0]     stab_m = 2'b00;
    logic           alarm_m = 1'b0;
    logic           ovf_m = 1'b0;
    logic [TSW-1:0] ts_m = '0;
    int             n_chk = 0;
    int             n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an event is due when a code differing from the stable one has
    // been seen on exactly DEB consecutive edges.
    always @(posedge clk) begin : model
        bit  pop_m, ev, drop;
        ev_t e;
        if (rst) begin
            occ = 0; run = 0; last_m = 2'b00; stab_m = 2'b00;
            alarm_m = 1'b0; ovf_m = 1'b0; ts_m = '0;
            exp_q.delete();
        end else begin
            pop_m = (occ > 0) && evt_ready;
            drop  = 1'b0;
            if (fault == last_m) begin
                if (run <= DEB) run++;
            end else begin
                last_m = fault;
                run    = 1;
            end
            ev = (run == DEB) && (fault != stab_m);
            if (ev) begin
                if (occ == DEPTH && !pop_m) drop = 1'b1;
                else begin
                    e.code = fault; e.prev = stab_m; e.rms = rms; e.ts = ts_m;
                    exp_q.push_back(e);
                    occ++;
                end
            end
            if (pop_m) occ--;
            if (ev && fault != 2'b00)              alarm_m = 1'b1;
            else if (alarm_clr && stab_m == 2'b00) alarm_m = 1'b0;
            if (drop)           ovf_m = 1'b1;
            else if (alarm_clr) ovf_m = 1'b0;
            if (ev) stab_m = fault;
            ts_m = ts_m + 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        chk("evt_valid", 64'(evt_valid), 64'(occ != 0));
        chk("stable", 64'(stable), 64'(stab_m));
        chk("alarm", 64'(alarm), 64'(alarm_m));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_event: got code %0d with no event expected at %0t", evt_code, $time);
            end else begin
                e = exp_q.pop_front();
                chk("evt_code", 64'(evt_code), 64'(e.code));
                chk("evt_prev", 64'(evt_prev), 64'(e.prev));
                chk("evt_rms", 64'(evt_rms), 64'(e.rms));
                chk("evt_ts", 64'(evt_ts), 64'(e.ts));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    task automatic hold(input logic [1:0] f, input int n);
        fault = f;
        for (int i = 0; i < n; i++) begin
            rms = $urandom;
            cyc(1);
        end
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int i = 0; i < 64 && occ != 0; i++) cyc(1);
        chk("drain_empty", 64'(evt_valid), 64'(0));
        evt_ready = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int pops;
        logic [1:0] seq [5];

        // reset and quiet input
        cyc(5);
        chk("rst_valid", 64'(evt_valid), 64'(0));
        chk("rst_code", 64'(evt_code), 64'(0));
        chk("rst_prev", 64'(evt_prev), 64'(0));
        chk("rst_rms", 64'(evt_rms), 64'(0));
        chk("rst_ts", 64'(evt_ts), 64'(0));
        chk("rst_stable", 64'(stable), 64'(0));
        chk("rst_alarm", 64'(alarm), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;
        hold(2'b00, 40);
        chk("healthy_no_event", 64'(evt_valid), 64'(0));

        // first qualification at a known timestamp
        for (int i = 0; i < 200 && ts_m != 16'd100; i++) cyc(1);
        rms   = 32'h1234;
        fault = 2'b01;
        cyc(15);
        chk("deb_15_not_yet", 64'(stable), 64'(0));
        cyc(1);
        chk("deb_16_stable", 64'(stable), 64'(1));
        chk("deb_16_alarm", 64'(alarm), 64'(1));
        chk("deb_16_valid", 64'(evt_valid), 64'(1));
        chk("deb_16_code", 64'(evt_code), 64'(1));
        chk("deb_16_prev", 64'(evt_prev), 64'(0));
        chk("deb_16_rms", 64'(evt_rms), 64'(32'h1234));
        chk("deb_16_ts", 64'(evt_ts), 64'(115));
        drain();

        // short glitches never qualify
        do_reset(2);
        hold(2'b10, 15);
        hold(2'b00, 20);
        chk("glitch_no_event", 64'(evt_valid), 64'(0));
        chk("glitch_stable", 64'(stable), 64'(0));
        chk("glitch_alarm", 64'(alarm), 64'(0));
        hold(2'b01, 15);
        hold(2'b10, 16);
        chk("switch_stable", 64'(stable), 64'(2));
        chk("switch_code", 64'(evt_code), 64'(2));
        chk("switch_prev", 64'(evt_prev), 64'(0));
        drain();

        // fill past capacity
        do_reset(2);
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00; seq[4] = 2'b01;
        for (int i = 0; i < 5; i++) hold(seq[i], 16);
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_head", 64'(evt_code), 64'(1));
        drain();

        // alarm_clr gated by stable code
        evt_ready = 1'b1;
        hold(2'b11, 16);
        alarm_clr = 1'b1;
        cyc(1);
        alarm_clr = 1'b0;
        chk("clr_ignored_alarm", 64'(alarm), 64'(1));
        chk("clr_overflow", 64'(overflow), 64'(0));
        hold(2'b00, 16);
        chk("healthy_alarm_kept", 64'(alarm), 64'(1));
        alarm_clr = 1'b1;
        cyc(1);
        alarm_clr = 1'b0;
        chk("clr_alarm", 64'(alarm), 64'(0));
        evt_ready = 1'b0;

        // push and pop together while full
        do_reset(2);
        for (int i = 0; i < 4; i++) hold(seq[i], 16);
        fault = 2'b01;
        cyc(15);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("full_pushpop_ovf", 64'(overflow), 64'(0));
        chk("full_pushpop_head", 64'(evt_code), 64'(2));
        pops = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!evt_valid) break;
            cyc(1);
            pops++;
        end
        evt_ready = 1'b0;
        chk("full_occupancy", 64'(pops), 64'(4));

        // reset during qualification
        hold(2'b10, 8);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_valid", 64'(evt_valid), 64'(0));
        chk("midrst_stable", 64'(stable), 64'(0));
        chk("midrst_alarm", 64'(alarm), 64'(0));
        cyc(15);
        chk("midrst_15", 64'(stable), 64'(0));
        cyc(1);
        chk("midrst_16", 64'(stable), 64'(2));
        drain();

        // randomized traffic
        for (int s = 0; s < 200; s++) begin
            fault = 2'($urandom_range(3));
            for (int k = $urandom_range(24, 1); k > 0; k--) begin
                rms       = $urandom;
                evt_ready = ($urandom_range(2) == 0);
                alarm_clr = ($urandom_range(15) == 0);
                rst       = ($urandom_range(999) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        alarm_clr = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
